usb_reg_bridge: RTL
===================

# usb_reg_bridge

Parametrised register bridge between the USB FIFO byte interface (`USB_D`, `USB_FWRn`, `USB_FRDn`, all synchronous to `CLK_USB`) and the FPGA fabric. It replaces direct 8-bit pin mirroring with an addressed protocol: single and burst writes into `NUM_OUT` byte registers, and addressed reads from `NUM_IN` byte input ports with optional auto-increment. It sits directly behind the USB chip pins; user logic consumes `dataout`/`dataout_we` and supplies `datain`.

## Interface
- `NUM_OUT`, default 4: number of output byte registers; range 1..64.
- `NUM_IN`, default 4: number of input byte ports; range 1..64.

Ports:
- `CLK_USB`  in  1  the only clock.
- `RST_USB`  in  1  reset; synchronous and active-high.
- `USB_FWRn`  in  1  host-write strobe, active low; one byte per `CLK_USB` cycle while low.
- `USB_FRDn`  in  1  host-read strobe, active low.
- `USB_D`  inout  8  USB data bus.
- `dataout`  out  `NUM_OUT*8`  output registers; register k is at `[8k+7:8k]`.
- `dataout_we`  out  `NUM_OUT`  one-cycle pulse per register, asserted when that register is written.
- `datain`  in  `NUM_IN*8`  input ports; port k is at `[8k+7:8k]`.
- `LED`  out  3  equal to `dataout[2:0]` (register 0, bits 2:0).

## Operation
- Command byte: bit7 W (1 = write, 0 = read), bit6 AI (auto-increment), bits[5:0] address.
- Parser states and transitions:
  - IDLE, on a byte:
    - W=1, AI=0: go to WDATA, count=1.
    - W=1, AI=1: go to WLEN.
    - W=0: load `rd_ptr` = addr and `rd_ai` = AI; stay in IDLE.
  - WLEN, on a byte: count = byte (0 means 256); go to WDATA.
  - WDATA, on a byte: write the byte to `wr_ptr`, increment `wr_ptr` (6-bit wrap), decrement count. Go to IDLE when count reaches 0.
- Writes to address ≥ `NUM_OUT` are discarded: no register change, no `we` pulse. The byte still consumes count.
- Read data:
  - `rd_data` register reloads each cycle from port `rd_ptr` while `USB_FRDn` is high, or loads 8'h00 if `rd_ptr` ≥ `NUM_IN`.
  - `rd_data` is frozen while `USB_FRDn` is low.
- `USB_D` is driven with `rd_data` when `USB_FRDn`=0 and is high-Z otherwise (combinational on `USB_FRDn`).
- The end of a read is detected as `USB_FRDn` rising (registered previous value 0, current value 1). At that point, if `rd_ai`=1, `rd_ptr` increments (6-bit wrap).
- If `USB_FWRn` and `USB_FRDn` are both low in the same cycle, the read wins. The write byte is ignored and the parser state is unchanged.
- Reset values:
  - `dataout`: all 0. `dataout_we`: 0. `LED`: 0.
  - Parser state: IDLE. `count`, `wr_ptr`, `rd_ptr`, `rd_ai`, `rd_data`: all 0.
  - `USB_D`: high-Z, or 8'h00 if `USB_FRDn` is low during reset.
- Reset in the middle of a burst abandons the remaining count. The next byte after reset is parsed as a command.

## Timing
- Byte capture happens on the `CLK_USB` edge where `USB_FWRn`=0.
- A write updates `dataout` at that same edge, so the new value is visible in the following cycle. `dataout_we` is high for exactly that one cycle.
- Back-to-back burst bytes on consecutive cycles are fully supported; throughput is 1 byte/cycle.
- Read command to first valid read data: `rd_ptr` updates at the command edge and `rd_data` reflects it one edge later. The host must leave ≥2 cycles between the command byte and the `USB_FRDn` fall.
- `datain` must be stable for 1 cycle before `USB_FRDn` falls. Changes to `datain` while `USB_FRDn` is low are not visible on `USB_D`.
- Auto-increment happens at the `USB_FRDn` rising edge. The next `rd_data` is valid one cycle later, so consecutive read strobes need ≥1 high cycle between them.

## Structure
- Package `usb_bridge_pkg` holds:
  - `CMD_W_BIT`=7, `CMD_AI_BIT`=6, `ADDR_W`=6;
  - the parser state enum (IDLE, WLEN, WDATA).
- Sub-module `usb_cmd_parser` contains the state machine, `count` and `wr_ptr`. It takes the qualified byte strobe and emits write-enable plus address. It also outputs the read-pointer load and AI value.
- The top level contains the output registers, read mux, `rd_data`, `USB_FRDn` edge detect and tri-state.

## Test plan
Directed scenarios, with `NUM_OUT`=4 and `NUM_IN`=4:
- **Reset:** apply `RST_USB` for 2 cycles with strobes high. Require `dataout`=0, `dataout_we`=0, `LED`=0, `USB_D`=Z.
- **Single write:** bytes 0x82, 0x5A. Require register 2 = 0x5A, `dataout_we`=4'b0100 for one cycle, other registers unchanged, `LED`=0.
- **Burst write:**
  - 0xC0, 0x03, 0x11, 0x22, 0x33. Require registers 0..2 = 0x11, 0x22, 0x33 and `LED`=3'b001.
  - Then 0xC3, 0x02, 0xAA, 0xBB. Require register 3 = 0xAA, 0xBB discarded with no `we` pulse, and the parser back in IDLE.
- **Auto-increment read:**
  - `datain` = {0x44, 0x33, 0x22, 0x11}, command 0x40, then three 2-cycle read strobes. Require `USB_D` = 0x11, 0x22, 0x33.
  - Command 0x05 then a read. Require 0x00.
- **Strobe hazards:**
  - Change `datain` while `USB_FRDn` is low. Require `USB_D` stable.
  - Assert `USB_FWRn` and `USB_FRDn` low together with 0x81 on the bus. Require no register write and the parser still in IDLE.
- **Reset mid-operation:** bytes 0xC0, 0x05, 0x01, then reset. Require `dataout`=0. Then bytes 0x81, 0x7E. Require register 1 = 0x7E.

Source files
------------

// File: rtl/usb_bridge_pkg.sv
// rtl/usb_bridge_pkg.sv - shared constants and parser state type for the USB register bridge
package usb_bridge_pkg;

    localparam int CMD_W_BIT  = 7;
    localparam int CMD_AI_BIT = 6;
    localparam int ADDR_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WLEN  = 2'd1,
        ST_WDATA = 2'd2
    } parser_state_t;

endpackage

// File: rtl/usb_cmd_parser.sv
// rtl/usb_cmd_parser.sv - command byte parser: write pointer, burst count, read pointer load
module usb_cmd_parser
    import usb_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_load,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ai
);

    parser_state_t     state_q, state_d;
    logic [8:0]        count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 9'd0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        rd_load  = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_data[CMD_W_BIT]) begin
                        wr_ptr_d = byte_data[ADDR_W-1:0];
                        if (byte_data[CMD_AI_BIT]) begin
                            state_d = ST_WLEN;
                        end else begin
                            state_d = ST_WDATA;
                            count_d = 9'd1;
                        end
                    end else begin
                        rd_load = 1'b1;
                    end
                end
                ST_WLEN: begin
                    // a zero length byte requests the maximum burst of 256
                    count_d = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
                    state_d = ST_WDATA;
                end
                ST_WDATA: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign wr_addr = wr_ptr_q;
    assign rd_addr = byte_data[ADDR_W-1:0];
    assign rd_ai   = byte_data[CMD_AI_BIT];

endmodule

// File: rtl/usb_reg_bridge.sv
// rtl/usb_reg_bridge.sv - addressed register bridge between the USB FIFO byte bus and fabric
module usb_reg_bridge
    import usb_bridge_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int NUM_IN  = 4
) (
    input  logic                 CLK_USB,
    input  logic                 RST_USB,
    input  logic                 USB_FWRn,
    input  logic                 USB_FRDn,
    inout  wire  [7:0]           USB_D,
    output logic [NUM_OUT*8-1:0] dataout,
    output logic [NUM_OUT-1:0]   dataout_we,
    input  logic [NUM_IN*8-1:0]  datain,
    output logic [2:0]           LED
);

    logic              byte_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ai;

    logic [NUM_OUT*8-1:0] dataout_q, dataout_d;
    logic [NUM_OUT-1:0]   we_q, we_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                 rd_ai_q, rd_ai_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 frdn_q;
    logic [7:0]           rd_sel;
    logic                 rd_end;

    // a simultaneous read strobe blocks the write byte entirely
    assign byte_valid = !USB_FWRn && USB_FRDn;
    assign rd_end     = !frdn_q && USB_FRDn;

    usb_cmd_parser u_parser (
        .clk        (CLK_USB),
        .rst        (RST_USB),
        .byte_valid (byte_valid),
        .byte_data  (USB_D),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_load    (rd_load),
        .rd_addr    (rd_addr),
        .rd_ai      (rd_ai)
    );

    always_ff @(posedge CLK_USB) begin
        if (RST_USB) begin
            dataout_q <= '0;
            we_q      <= '0;
            rd_ptr_q  <= '0;
            rd_ai_q   <= 1'b0;
            rd_data_q <= 8'h00;
            frdn_q    <= 1'b1;
        end else begin
            dataout_q <= dataout_d;
            we_q      <= we_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_ai_q   <= rd_ai_d;
            rd_data_q <= rd_data_d;
            frdn_q    <= USB_FRDn;
        end
    end

    // addresses with no matching register fall through: no update, no pulse
    always_comb begin
        dataout_d = dataout_q;
        we_d      = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (wr_en && (wr_addr == ADDR_W'(k))) begin
                dataout_d[8*k +: 8] = USB_D;
                we_d[k]             = 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel = 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rd_ptr_q == ADDR_W'(k)) begin
                rd_sel = datain[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        rd_ai_d   = rd_ai_q;
        rd_data_d = USB_FRDn ? rd_sel : rd_data_q;
        if (rd_load) begin
            rd_ptr_d = rd_addr;
            rd_ai_d  = rd_ai;
        end else if (rd_end && rd_ai_q) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign USB_D      = USB_FRDn ? 8'bz : rd_data_q;
    assign dataout    = dataout_q;
    assign dataout_we = we_q;
    assign LED        = dataout_q[2:0];

endmodule
